// File: rtl/if_prefetch.sv
// Instruction-fetch front end: PC generator, in-order imem request/response
// port and a DEPTH-entry prefetch queue feeding decode under valid/ready.
module if_prefetch #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [ILEN-1:0] imem_rdata_i,
  input  logic            imem_err_i,
  output logic            inst_valid_o,
  output logic [ILEN-1:0] inst_data_o,
  output logic [XLEN-1:0] inst_pc_o,
  output logic            inst_err_o,
  input  logic            inst_ready_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XLEN-1:0] STEP       = XLEN'(ILEN / 8);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(ILEN / 8 - 1);
  localparam logic [CW:0]     CREDITS    = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;

  logic [XLEN-1:0] q_pc   [DEPTH];
  logic [ILEN-1:0] q_data [DEPTH];
  logic            q_err  [DEPTH];
  logic [AW-1:0]   q_rd, q_wr;
  logic [CW-1:0]   q_count;

  logic [XLEN-1:0] pf_pc [DEPTH];
  logic [AW-1:0]   pf_rd, pf_wr;

  logic [CW-1:0]   inflight, discard, inflight_next;
  logic [CW:0]     credit_used;
  logic            grant, resp, drop, push, pop;

  // Queued entries plus in-flight fetches never exceed DEPTH, so a response
  // always finds room in the queue.
  assign credit_used   = {1'b0, q_count} + {1'b0, inflight};
  assign imem_req_o    = !rst_i && !redirect_i && (credit_used < CREDITS);
  assign imem_addr_o   = fetch_pc;

  assign grant         = imem_req_o && imem_gnt_i;
  assign resp          = imem_rvalid_i;
  assign drop          = (discard != '0);
  assign push          = resp && !drop && !redirect_i;
  assign pop           = (q_count != '0) && inst_ready_i && !redirect_i;
  assign inflight_next = inflight + CW'(grant) - CW'(resp);

  assign inst_valid_o  = (q_count != '0);
  assign inst_pc_o     = q_pc[q_rd];
  assign inst_data_o   = q_data[q_rd];
  assign inst_err_o    = q_err[q_rd];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
      pf_rd    <= '0;
      pf_wr    <= '0;
      q_rd     <= '0;
      q_wr     <= '0;
      q_count  <= '0;
    end else begin
      inflight <= inflight_next;
      if (grant) pf_wr <= pf_wr + AW'(1);
      if (resp)  pf_rd <= pf_rd + AW'(1);
      if (redirect_i) begin
        // Everything still outstanding after this cycle belongs to the old stream.
        fetch_pc <= redirect_pc_i & ALIGN_MASK;
        discard  <= inflight_next;
        q_rd     <= '0;
        q_wr     <= '0;
        q_count  <= '0;
      end else begin
        if (grant)        fetch_pc <= fetch_pc + STEP;
        if (resp && drop) discard  <= discard - CW'(1);
        if (push)         q_wr     <= q_wr + AW'(1);
        if (pop)          q_rd     <= q_rd + AW'(1);
        q_count <= q_count + CW'(push) - CW'(pop);
      end
    end
  end

  // NOTE: the queue storage is reset because its head drives decode outputs
  // that must read zero out of reset; the PC FIFO is not, as every entry is
  // written on grant before its response can read it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]   <= '0;
        q_data[i] <= '0;
        q_err[i]  <= 1'b0;
      end
    end else if (push) begin
      q_pc[q_wr]   <= pf_pc[pf_rd];
      q_data[q_wr] <= imem_rdata_i;
      q_err[q_wr]  <= imem_err_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant) pf_pc[pf_wr] <= fetch_pc;
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: in-order memory model with random
// grant/latency and a stream-level scoreboard of delivered {pc, data, err}.
module tb_if_prefetch;
  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic            clk_i = 1'b0;
  logic            rst_i, redirect_i, imem_req_o, imem_gnt_i, imem_rvalid_i, imem_err_i;
  logic            inst_valid_o, inst_err_o, inst_ready_i;
  logic [31:0]     redirect_pc_i, imem_addr_o, imem_rdata_i, inst_data_o, inst_pc_o;

  if_prefetch #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .imem_err_i(imem_err_i),
    .inst_valid_o(inst_valid_o), .inst_data_o(inst_data_o), .inst_pc_o(inst_pc_o),
    .inst_err_o(inst_err_o), .inst_ready_i(inst_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t pend[$];

  int cyc = 0, checks = 0, errors = 0, pops = 0, last_due = 0;
  int gnt_mode = 0, lat_mode = 0, lat_fixed = 1;
  logic drv_rst = 1'b1, drv_redirect = 1'b0, drv_ready = 1'b1;
  logic [31:0] drv_target = '0;
  logic err_en = 1'b0, rand_err = 1'b0;
  logic [31:0] err_pc = '0;
  logic [31:0] m_fetch = RESET_PC, m_exp = RESET_PC;
  logic last_req, last_grant, last_pop, last_pop_err, last_rvalid;
  logic [31:0] last_addr, last_pop_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic err_of(input logic [31:0] a);
    return (err_en && a == err_pc) || (rand_err && a[5:2] == 4'hB);
  endfunction

  // One clock: drive at the falling edge, observe 1 ns later, advance the model.
  task automatic cycle();
    pend_t h;
    int    due;
    rst_i         = drv_rst;
    redirect_i    = drv_redirect;
    redirect_pc_i = drv_target;
    inst_ready_i  = drv_ready;
    imem_gnt_i    = (gnt_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    imem_err_i    = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      h = pend.pop_front();
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(h.addr);
      imem_err_i    = err_of(h.addr);
    end
    #1;
    last_rvalid  = imem_rvalid_i;
    last_req     = imem_req_o;
    last_addr    = imem_addr_o;
    last_grant   = (imem_req_o === 1'b1) && imem_gnt_i;
    last_pop     = (inst_valid_o === 1'b1) && inst_ready_i && !redirect_i && !rst_i;
    last_pop_pc  = inst_pc_o;
    last_pop_err = inst_err_o;
    if (rst_i || redirect_i) begin
      checks++;
      if (imem_req_o !== 1'b0) begin
        errors++;
        $display("FAIL req_blocked: cycle %0d req=%b required 0", cyc, imem_req_o);
      end
    end else if (imem_req_o === 1'b1) begin
      checks++;
      if (imem_addr_o !== m_fetch) begin
        errors++;
        $display("FAIL fetch_addr: cycle %0d addr=%h required %h", cyc, imem_addr_o, m_fetch);
      end
    end
    if (last_pop) begin
      checks++;
      if (inst_pc_o !== m_exp || inst_data_o !== mem_word(m_exp) || inst_err_o !== err_of(m_exp)) begin
        errors++;
        $display("FAIL deliver: cycle %0d pc=%h data=%h err=%b required pc=%h data=%h err=%b",
                 cyc, inst_pc_o, inst_data_o, inst_err_o, m_exp, mem_word(m_exp), err_of(m_exp));
      end
      m_exp += 32'd4;
      pops++;
    end
    if (last_grant) begin
      due = cyc + ((lat_mode == 0) ? lat_fixed : int'($urandom_range(1, 3)));
      if (due <= last_due) due = last_due + 1;
      pend.push_back('{imem_addr_o, due});
      last_due = due;
    end
    if (rst_i) begin
      pend.delete();
      last_due = 0;
      m_fetch  = RESET_PC;
      m_exp    = RESET_PC;
    end else if (redirect_i) begin
      m_fetch = redirect_pc_i & ~32'h3;
      m_exp   = redirect_pc_i & ~32'h3;
    end else if (last_grant) begin
      m_fetch += 32'd4;
    end
    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    drv_rst = 1'b1;
    cycle();
    drv_rst = 1'b0;
  endtask

  task automatic wait_pop(input int limit, output logic found);
    found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      cycle();
      if (last_pop) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    drv_rst = 1'b1; drv_ready = 1'b1; gnt_mode = 0; lat_mode = 0; lat_fixed = 1;
    cycle();
    cycle();
    checks++;
    if (inst_valid_o !== 1'b0 || inst_data_o !== '0 || inst_pc_o !== '0 || inst_err_o !== 1'b0
        || imem_addr_o !== RESET_PC || imem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h pc=%h err=%b addr=%h req=%b required 0/0/0/0/%h/0",
               inst_valid_o, inst_data_o, inst_pc_o, inst_err_o, imem_addr_o, imem_req_o, RESET_PC);
    end
    drv_rst = 1'b0;
    cycle();
    checks++;
    if (last_req !== 1'b1 || last_addr !== RESET_PC) begin
      errors++;
      $display("FAIL first_req: req=%b addr=%h required 1 and %h", last_req, last_addr, RESET_PC);
    end
    cycle();
    checks++;
    if (last_pop !== 1'b0) begin
      errors++;
      $display("FAIL no_fallthrough: pop one cycle after grant, pc=%h required none", last_pop_pc);
    end
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (last_pop !== 1'b1 || last_pop_pc !== 32'(4 * k)) begin
        errors++;
        $display("FAIL stream_pc%0d: pop=%b pc=%h required 1 and %h", k, last_pop, last_pop_pc, 32'(4 * k));
      end
    end
  endtask

  task automatic test_backpressure();
    int grants = 0;
    do_reset();
    drv_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (last_grant) grants++;
    end
    checks++;
    if (grants != DEPTH || last_req !== 1'b0 || inst_valid_o !== 1'b1 || pend.size() != 0) begin
      errors++;
      $display("FAIL bp_fill: grants=%0d req=%b valid=%b pending=%0d required %0d/0/1/0",
               grants, last_req, inst_valid_o, pend.size(), DEPTH);
    end
    drv_ready = 1'b1;
    cycle();
    checks++;
    if (last_pop !== 1'b1 || last_req !== 1'b0) begin
      errors++;
      $display("FAIL bp_first_pop: pop=%b req=%b required 1 and 0", last_pop, last_req);
    end
    cycle();
    checks++;
    if (last_req !== 1'b1) begin
      errors++;
      $display("FAIL bp_resume: req=%b required 1", last_req);
    end
  endtask

  task automatic test_redirect();
    logic found;
    int   guard = 0;
    lat_mode = 0; lat_fixed = 2; gnt_mode = 0; drv_ready = 1'b1;
    while (pend.size() != 2 && guard < 20) begin cycle(); guard++; end
    checks++;
    if (pend.size() != 2) begin
      errors++;
      $display("FAIL redir_setup: in flight=%0d required 2", pend.size());
    end
    drv_redirect = 1'b1; drv_target = 32'h100;
    cycle();
    drv_redirect = 1'b0;
    wait_pop(20, found);
    checks++;
    if (!found || last_pop_pc !== 32'h100) begin
      errors++;
      $display("FAIL redir_first_pc: found=%b pc=%h required 1 and 00000100", found, last_pop_pc);
    end
    drv_redirect = 1'b1; drv_target = 32'h103;
    cycle();
    drv_redirect = 1'b0;
    cycle();
    checks++;
    if (last_req !== 1'b1 || last_addr !== 32'h100) begin
      errors++;
      $display("FAIL redir_align_req: req=%b addr=%h required 1 and 00000100", last_req, last_addr);
    end
    wait_pop(20, found);
    checks++;
    if (!found || last_pop_pc !== 32'h100) begin
      errors++;
      $display("FAIL redir_align_pc: found=%b pc=%h required 1 and 00000100", found, last_pop_pc);
    end
  endtask

  task automatic test_simultaneous();
    logic found;
    int   guard = 0;
    lat_mode = 0; lat_fixed = 1; gnt_mode = 0;
    while (!(pend.size() == 1 && pend[0].due <= cyc) && guard < 20) begin cycle(); guard++; end
    drv_redirect = 1'b1; drv_target = 32'h200;
    cycle();
    drv_redirect = 1'b0;
    checks++;
    if (last_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL simul_setup: rvalid in redirect cycle=%b required 1", last_rvalid);
    end
    wait_pop(20, found);
    checks++;
    if (!found || last_pop_pc !== 32'h200) begin
      errors++;
      $display("FAIL simul_first_pc: found=%b pc=%h required 1 and 00000200", found, last_pop_pc);
    end
    for (int i = 0; i < 6; i++) cycle();
  endtask

  task automatic test_error();
    logic found = 1'b0;
    do_reset();
    err_en = 1'b1; err_pc = 32'h8;
    for (int i = 0; i < 30 && !found; i++) begin
      cycle();
      if (last_pop && last_pop_pc == 32'h8) found = 1'b1;
    end
    checks++;
    if (!found || last_pop_err !== 1'b1) begin
      errors++;
      $display("FAIL err_flag: found=%b err=%b required 1 and 1", found, last_pop_err);
    end
    wait_pop(20, found);
    checks++;
    if (!found || last_pop_pc !== 32'hC || last_pop_err !== 1'b0) begin
      errors++;
      $display("FAIL err_continue: pc=%h err=%b required 0000000c and 0", last_pop_pc, last_pop_err);
    end
    err_en = 1'b0;
  endtask

  task automatic test_wrap_and_reset();
    logic found;
    drv_redirect = 1'b1; drv_target = 32'hFFFF_FFFC;
    cycle();
    drv_redirect = 1'b0;
    wait_pop(20, found);
    checks++;
    if (!found || last_pop_pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_top: pc=%h required fffffffc", last_pop_pc);
    end
    wait_pop(20, found);
    checks++;
    if (!found || last_pop_pc !== 32'h0) begin
      errors++;
      $display("FAIL wrap_zero: pc=%h required 00000000", last_pop_pc);
    end
    drv_ready = 1'b0;
    cycle();
    cycle();
    do_reset();
    drv_ready = 1'b1;
    checks++;
    if (inst_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_empty: valid=%b required 0", inst_valid_o);
    end
    cycle();
    checks++;
    if (last_req !== 1'b1 || last_addr !== RESET_PC) begin
      errors++;
      $display("FAIL midreset_req: req=%b addr=%h required 1 and %h", last_req, last_addr, RESET_PC);
    end
  endtask

  task automatic test_random();
    int start_pops;
    gnt_mode = 1; lat_mode = 1; rand_err = 1'b1;
    start_pops = pops;
    for (int i = 0; i < 3000; i++) begin
      drv_ready    = ($urandom_range(0, 3) != 0);
      drv_redirect = ($urandom_range(0, 39) == 0);
      drv_target   = $urandom;
      cycle();
    end
    drv_redirect = 1'b0;
    checks++;
    if (pops - start_pops < 200) begin
      errors++;
      $display("FAIL random_progress: delivered=%0d required at least 200", pops - start_pops);
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_redirect();
    test_simultaneous();
    test_error();
    test_wrap_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
